// File: rtl/spi_frame_rx.sv
// spi_frame_rx: SPI slave frame receiver (CPOL=0/CPHA=0), oversampled in the clk domain.
// Receives an MSB-first frame of FRAME_BITS bits framed by an active-low load, and
// hands it downstream with a valid/ready handshake. It flags short frames and
// overruns with sticky error bits.
// Optional feature macro: SPI_ECHO_EN. When it is defined, the last accepted frame is
// shifted back out on sdo during the next frame.
module spi_frame_rx #(
    parameter int  FRAME_BITS  = 128,
    parameter int  SYNC_STAGES = 2,
    localparam int CNT_W       = $clog2(FRAME_BITS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sck,
    input  logic                  sdi,
    input  logic                  load,
    output logic                  sdo,
    output logic [FRAME_BITS-1:0] frame_data,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic [CNT_W-1:0]      bit_count,
    output logic                  err_short,
    output logic                  err_overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [SYNC_STAGES-1:0] sck_pipe;
    logic [SYNC_STAGES-1:0] sdi_pipe;
    logic [SYNC_STAGES-1:0] load_pipe;
    logic                   sck_prev;
    logic                   sck_s;
    logic                   sdi_s;
    logic                   load_s;
    logic                   sck_rise;
    logic                   armed;
    logic                   frame_full;
    logic [FRAME_BITS-1:0]  shift_reg;

    logic do_enter;
    logic do_shift;
    logic do_commit;
    logic do_abort;

    // Bring sck, sdi and load into the clk domain. One extra sck flop is kept for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_pipe  <= '0;
            sdi_pipe  <= '0;
            load_pipe <= '0;
            sck_prev  <= 1'b0;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values; with = the
            // pipeline would collapse into a single stage.
            sck_pipe  <= {sck_pipe[SYNC_STAGES-2:0], sck};
            sdi_pipe  <= {sdi_pipe[SYNC_STAGES-2:0], sdi};
            load_pipe <= {load_pipe[SYNC_STAGES-2:0], load};
            sck_prev  <= sck_s;
        end
    end

    assign sck_s      = sck_pipe[SYNC_STAGES-1];
    assign sdi_s      = sdi_pipe[SYNC_STAGES-1];
    assign load_s     = load_pipe[SYNC_STAGES-1];
    assign sck_rise   = sck_s & ~sck_prev;
    assign frame_full = (bit_count == CNT_W'(FRAME_BITS));

    // The load synchroniser resets to 0, which reads as "frame in progress" until the pin
    // propagates. Frames start only after load has been seen high once, so no bogus short
    // frame can follow reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed <= 1'b0;
        end else if (load_s) begin
            armed <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and datapath strobes. A completed frame takes priority over a late load rise.
    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that leaves one
        // unassigned would infer a latch.
        next_state = state;
        do_enter   = 1'b0;
        do_shift   = 1'b0;
        do_commit  = 1'b0;
        do_abort   = 1'b0;
        unique case (state)
            IDLE: begin
                if (armed && !load_s) begin
                    next_state = SHIFT;
                    do_enter   = 1'b1;
                end
            end
            SHIFT: begin
                if (frame_full) begin
                    do_commit  = 1'b1;
                    next_state = HOLD;
                end else if (load_s) begin
                    do_abort   = 1'b1;
                    next_state = IDLE;
                end else if (sck_rise) begin
                    do_shift   = 1'b1;
                end
            end
            HOLD: begin
                if (load_s) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Shift register and bit counter. The counter is held at 0 whenever the FSM is in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the wide shift and frame registers are reset too: reset must leave
            // all-zero outputs and a deterministic echo.
            shift_reg <= '0;
            bit_count <= '0;
        end else begin
            if (next_state == IDLE) begin
                bit_count <= '0;
            end else if (do_shift) begin
                bit_count <= bit_count + CNT_W'(1);
            end
            if (do_shift) begin
                shift_reg <= {shift_reg[FRAME_BITS-2:0], sdi_s};
            end
        end
    end

    // Output handshake: commit, drop on overrun, and clear valid after acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_data  <= '0;
            frame_valid <= 1'b0;
            err_overrun <= 1'b0;
        end else if (do_commit) begin
            if (frame_valid && !frame_ready) begin
                err_overrun <= 1'b1;
            end else begin
                frame_data  <= shift_reg;
                frame_valid <= 1'b1;
            end
        end else if (frame_valid && frame_ready) begin
            frame_valid <= 1'b0;
        end
    end

    // Sticky short-frame flag, raised when load rises before the frame is complete.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_short <= 1'b0;
        end else if (do_abort) begin
            err_short <= 1'b1;
        end
    end

`ifdef SPI_ECHO_EN
    logic                  sck_fall;
    logic [FRAME_BITS-1:0] tx_reg;

    assign sck_fall = ~sck_s & sck_prev;

    // Echo register: load the last accepted frame on frame entry, then advance on each sck fall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_reg <= '0;
        end else if (do_enter) begin
            tx_reg <= frame_data;
        end else if (state == SHIFT && sck_fall) begin
            tx_reg <= {tx_reg[FRAME_BITS-2:0], 1'b0};
        end
    end

    assign sdo = (state == SHIFT) ? tx_reg[FRAME_BITS-1] : 1'b0;
`else
    assign sdo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_frame_rx.sv
// tb_spi_frame_rx: directed, table-driven bench for spi_frame_rx (128-bit frames).
// The sdo echo expectations depend on SPI_ECHO_EN in the same way as the design.
module tb_spi_frame_rx;

    localparam int FB = 128;
    localparam int CW = $clog2(FB + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sck = 1'b0;
    logic          sdi = 1'b0;
    logic          load = 1'b1;
    logic          sdo;
    logic [FB-1:0] frame_data;
    logic          frame_valid;
    logic          frame_ready = 1'b1;
    logic [CW-1:0] bit_count;
    logic          err_short;
    logic          err_overrun;

    int errors = 0;
    int checks = 0;
    int valid_cycles = 0;

    spi_frame_rx #(.FRAME_BITS(FB), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .sck         (sck),
        .sdi         (sdi),
        .load        (load),
        .sdo         (sdo),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .bit_count   (bit_count),
        .err_short   (err_short),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    // Count the clock cycles in which frame_valid is high; this measures the pulse width.
    always @(posedge clk) begin
        if (frame_valid) valid_cycles++;
    end

    typedef struct {
        logic [FB-1:0] data;
        int            nbits;
        int            gap;
        logic [FB-1:0] exp_data;
        logic          exp_valid;
        logic          exp_short;
        logic          exp_ovr;
        int            exp_pulses;
        int            exp_bc;
        logic [FB-1:0] exp_echo;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [FB-1:0] act, input logic [FB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // The expected echo is the previously accepted frame with echo enabled, and 0 otherwise.
    function automatic logic [FB-1:0] echo_of(input logic [FB-1:0] prev);
`ifdef SPI_ECHO_EN
        return prev;
`else
        return '0;
`endif
    endfunction

    // Keep only the first nbits (MSB-first) of an expected echo value.
    function automatic logic [FB-1:0] top_mask(input int nbits);
        logic [FB-1:0] m = '0;
        for (int i = 0; i < nbits && i < FB; i++) m[FB-1-i] = 1'b1;
        return m;
    endfunction

    // Drive one SPI frame with sck half-periods of 6 clks. sdo is sampled just before each rise.
    // bc captures bit_count after the last bit and before load is raised.
    task automatic send_frame(input logic [FB-1:0] data, input int nbits, input bit raise,
                              input int gap, output logic [FB-1:0] echo, output int bc);
        @(negedge clk);
        load = 1'b0;
        repeat (8) @(negedge clk);
        echo = '0;
        for (int i = 0; i < nbits; i++) begin
            sdi = (i < FB) ? data[FB-1-i] : 1'b1;
            repeat (6) @(negedge clk);
            if (i < FB) echo[FB-1-i] = sdo;
            sck = 1'b1;
            repeat (6) @(negedge clk);
            sck = 1'b0;
        end
        repeat (6) @(negedge clk);
        bc = int'(bit_count);
        if (raise) begin
            load = 1'b1;
            repeat (gap) @(negedge clk);
        end
    endtask

    initial begin
        logic [FB-1:0] echo;
        logic [FB-1:0] ones;
        int            bc;
        int            v0;

        ones = '1;

        vecs[0] = '{data: {8{16'hAAAA}}, nbits: 128, gap: 8, exp_data: {8{16'hAAAA}},
                    exp_valid: 1'b0, exp_short: 1'b0, exp_ovr: 1'b0, exp_pulses: 1,
                    exp_bc: 128, exp_echo: echo_of('0)};
        vecs[1] = '{data: {4{32'hDEADBEEF}}, nbits: 40, gap: 8, exp_data: {8{16'hAAAA}},
                    exp_valid: 1'b0, exp_short: 1'b1, exp_ovr: 1'b0, exp_pulses: 0,
                    exp_bc: 40, exp_echo: echo_of({8{16'hAAAA}})};
        vecs[2] = '{data: 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, nbits: 128, gap: 1,
                    exp_data: 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                    exp_valid: 1'b0, exp_short: 1'b1, exp_ovr: 1'b0, exp_pulses: 1,
                    exp_bc: 128, exp_echo: echo_of({8{16'hAAAA}})};
        vecs[3] = '{data: {16{8'h5A}}, nbits: 130, gap: 8, exp_data: {16{8'h5A}},
                    exp_valid: 1'b0, exp_short: 1'b1, exp_ovr: 1'b0, exp_pulses: 1,
                    exp_bc: 128, exp_echo: echo_of(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210)};

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset data", frame_data, '0);
        check("reset valid", FB'(frame_valid), '0);
        check("reset bit_count", FB'(bit_count), '0);
        check("reset err_short", FB'(err_short), '0);
        check("reset err_overrun", FB'(err_overrun), '0);
        check("reset sdo", FB'(sdo), '0);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        // Table-driven frames: basic, short, re-arm after a 1-cycle load gap, extra clocks.
        for (int i = 0; i < 4; i++) begin
            v0 = valid_cycles;
            send_frame(vecs[i].data, vecs[i].nbits, 1'b1, vecs[i].gap, echo, bc);
            check($sformatf("row%0d data", i), frame_data, vecs[i].exp_data);
            check($sformatf("row%0d valid", i), FB'(frame_valid), FB'(vecs[i].exp_valid));
            check($sformatf("row%0d err_short", i), FB'(err_short), FB'(vecs[i].exp_short));
            check($sformatf("row%0d err_overrun", i), FB'(err_overrun), FB'(vecs[i].exp_ovr));
            check($sformatf("row%0d valid pulse cycles", i), FB'(valid_cycles - v0),
                  FB'(vecs[i].exp_pulses));
            check($sformatf("row%0d bit_count at end", i), FB'(bc), FB'(vecs[i].exp_bc));
            check($sformatf("row%0d echo", i), echo, vecs[i].exp_echo & top_mask(vecs[i].nbits));
        end
        check("bit_count idle", FB'(bit_count), '0);

        // Overrun: frame A is held unaccepted, and frame B is then dropped.
        frame_ready = 1'b0;
        send_frame(ones, 128, 1'b1, 8, echo, bc);
        check("ovr A valid", FB'(frame_valid), FB'(1));
        check("ovr A data", frame_data, ones);
        check("ovr A err_overrun", FB'(err_overrun), '0);
        send_frame('0, 128, 1'b1, 8, echo, bc);
        check("ovr B data kept", frame_data, ones);
        check("ovr B err_overrun", FB'(err_overrun), FB'(1));
        check("ovr B valid", FB'(frame_valid), FB'(1));
        check("ovr B echo", echo, echo_of(ones));
        frame_ready = 1'b1;
        @(negedge clk);
        check("ovr valid clears", FB'(frame_valid), '0);
        check("ovr data after accept", frame_data, ones);

        // Asynchronous reset in the middle of a frame, at bit 64.
        send_frame({16{8'h33}}, 64, 1'b0, 0, echo, bc);
        check("mid bit_count", FB'(bc), FB'(64));
        #3 reset = 1'b1;
        #1;
        check("async data", frame_data, '0);
        check("async valid", FB'(frame_valid), '0);
        check("async bit_count", FB'(bit_count), '0);
        check("async err_short", FB'(err_short), '0);
        check("async err_overrun", FB'(err_overrun), '0);
        check("async sdo", FB'(sdo), '0);
        load = 1'b1;
        sck  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        v0 = valid_cycles;
        send_frame({8{16'h5555}}, 128, 1'b1, 8, echo, bc);
        check("post-reset data", frame_data, {8{16'h5555}});
        check("post-reset valid pulse", FB'(valid_cycles - v0), FB'(1));
        check("post-reset err_short", FB'(err_short), '0);
        check("post-reset err_overrun", FB'(err_overrun), '0);
        check("post-reset echo", echo, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_frame_rx.md
Name: spi_frame_rx

Overview:
- Parametrised SPI slave frame receiver; successor to the fixed 128-bit MCU link receiver.
- Oversamples sck/sdi/load in the system clock domain, giving one clock for all logic.
- Shifts an MSB-first frame of FRAME_BITS bits and presents it with a valid/ready handshake to the downstream unpacker (coordinate/colour fields).
- Adds short-frame and overrun detection, plus optional echo of the last frame on sdo.

Parameters:
- FRAME_BITS, 128, bits per frame; legal range 8..256.
- SYNC_STAGES, 2, synchroniser depth on sck, sdi and load; legal range 2..3.
- CNT_W, $clog2(FRAME_BITS+1), bit-counter width; derived, not overridden.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- sck  in  1  SPI clock from MCU, CPOL=0/CPHA=0, asynchronous to clk.
- sdi  in  1  SPI data from MCU; sampled on sck rising edge.
- load  in  1  frame delimiter; high = idle/abort, low = frame in progress.
- sdo  out  1  SPI data to MCU; changes after sck falling edge.
- frame_data  out  FRAME_BITS  last accepted frame; first bit received lands in MSB.
- frame_valid  out  1  frame_data holds an unconsumed frame.
- frame_ready  in  1  consumer accepts frame_data when frame_valid && frame_ready.
- bit_count  out  CNT_W  bits received in the current frame.
- err_short  out  1  sticky: load rose before FRAME_BITS bits were received.
- err_overrun  out  1  sticky: a frame completed while frame_valid was held and not accepted.

Behaviour:
- Reset (async assert, sync release): all outputs 0; state IDLE; shift register, tx register and synchronisers 0.
- Synchronise sck, sdi and load through SYNC_STAGES flops.
- Derive sck_rise and sck_fall from the last synchroniser stage and one extra flop.
- Latency from a pin edge to sck_rise is SYNC_STAGES+1 clk cycles.
- sck high and low times must each be at least SYNC_STAGES+2 clk periods; faster sck is unsupported and unchecked.
- State machine: IDLE, SHIFT, HOLD.
  - IDLE: bit_count=0; sck edges ignored. When synced load is low, go to SHIFT and copy frame_data into the tx register.
  - SHIFT: on each sck_rise, shift_reg <= {shift_reg[FRAME_BITS-2:0], sdi_sync} and bit_count++.
    - If the sck_rise is for bit FRAME_BITS-1, on the next clk: commit shift_reg to frame_data, set frame_valid, go to HOLD.
    - If synced load goes high with bit_count < FRAME_BITS: discard the frame, set err_short, go to IDLE. frame_data and frame_valid are unchanged.
  - HOLD: further sck edges are ignored (no shift, no error). When synced load goes high, go to IDLE.
- Commit rules:
  - If frame_valid=1 and frame_ready=0 in the commit cycle: frame_data is NOT overwritten, the new frame is dropped, and err_overrun is set.
  - If frame_valid=1 and frame_ready=1 in the commit cycle: the new frame is written, frame_valid stays 1, and there is no overrun.
  - Otherwise frame_valid clears on the cycle after frame_valid && frame_ready.
- load high for exactly one synced cycle between frames is sufficient to re-arm.
- err_short and err_overrun clear only on reset.
- bit_count saturates at FRAME_BITS and returns to 0 in IDLE.
- Reset mid-frame: immediate return to IDLE, all outputs 0, partial frame lost.

Optional Feature:
- SPI_ECHO_EN defined:
  - The tx register loaded on entry to SHIFT is shifted out MSB-first.
  - sdo = tx[FRAME_BITS-1] after SHIFT entry; the register shifts left on each sck_fall while in SHIFT.
  - The MCU reads back the previously accepted frame, for link loopback checking.
  - sdo=0 in IDLE and HOLD.
- SPI_ECHO_EN undefined: sdo is tied to 0 and no tx register is built.

Test Plan:
- Basic frame: reset, drop load, clock 128 bits of 0xAAAA_..._AAAA (x_1 field = 10'b1010101010), raise load, frame_ready=1. Expected: frame_data=0xAAAA_..._AAAA; frame_valid high exactly 1 cycle; bit_count=128 before IDLE; no errors.
- Short frame: drop load, clock 40 bits, raise load. Expected: err_short=1; frame_valid stays 0; frame_data unchanged; the next full frame 0x0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 is received correctly.
- Overrun: frame_ready=0, send frame A=all-ones then frame B=all-zeros. Expected: frame_data=all-ones, err_overrun=1, frame_valid=1. Then assert frame_ready: frame_valid clears 1 cycle later.
- Extra clocks: send 130 sck pulses in one frame. Expected: frame_data holds the first 128 bits; pulses 129-130 ignored; no errors.
- Async reset at bit 64: assert reset. Expected: all outputs 0 immediately. Release reset and send a full frame 0x5555...: received correctly.
- With SPI_ECHO_EN, FRAME_BITS=16: accept 0xBEEF, then send 0x0000. Expected: the 16 bits on sdo, sampled on sck rising edges, read 0xBEEF.
